// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed 4-digit display driver with blanking and frame-synchronous double buffering
module seven_segment_scanner #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [31:0] digitData,
  input  logic [3:0]  digitMask,
  input  logic        loadValid,
  output logic        loadReady,
  output logic [7:0]  sevenSegmentData,
  output logic [3:0]  sevenSegmentEnable,
  output logic        frameStart
);
  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] dig_q, dig_d;
  logic start_q;
  logic [31:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [3:0] pend_mask_q, pend_mask_d, act_mask_q, act_mask_d;
  logic pend_full_q, pend_full_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] en_q, en_d;
  logic fs_q, fs_d;
  logic accept, bnd, wrap, show;
  assign loadReady = !pend_full_q;
  assign sevenSegmentData = seg_q;
  assign sevenSegmentEnable = en_q;
  assign frameStart = fs_q;
  // start_q makes the first edge after reset a frame boundary
  always_comb begin
    accept = loadValid && !pend_full_q;
    wrap = cnt_q == LAST;
    bnd = start_q || (wrap && dig_q == 2'd3);
    cnt_d = (bnd || wrap) ? '0 : cnt_q + 1'b1;
    dig_d = bnd ? 2'd0 : (wrap ? dig_q + 2'd1 : dig_q);
    act_data_d = (bnd && pend_full_q) ? pend_data_q : act_data_q;
    act_mask_d = (bnd && pend_full_q) ? pend_mask_q : act_mask_q;
    pend_data_d = accept ? digitData : pend_data_q;
    pend_mask_d = accept ? digitMask : pend_mask_q;
    pend_full_d = accept || (pend_full_q && !bnd);
    state_d = (cnt_d < BLANK_END) ? BLANK : SHOW;
    show = (state_d == SHOW) && act_mask_d[dig_d];
    en_d = show ? ~(4'b0001 << dig_d) : 4'hF;
    seg_d = show ? act_data_d[{dig_d, 3'b000} +: 8] : 8'hFF;
    fs_d = bnd;
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= BLANK;
      cnt_q <= '0;
      dig_q <= 2'd0;
      start_q <= 1'b1;
      pend_data_q <= 32'hFFFF_FFFF;
      pend_mask_q <= 4'h0;
      pend_full_q <= 1'b0;
      act_data_q <= 32'hFFFF_FFFF;
      act_mask_q <= 4'h0;
      seg_q <= 8'hFF;
      en_q <= 4'hF;
      fs_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      start_q <= 1'b0;
      pend_data_q <= pend_data_d;
      pend_mask_q <= pend_mask_d;
      pend_full_q <= pend_full_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
      seg_q <= seg_d;
      en_q <= en_d;
      fs_q <= fs_d;
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed frame-by-frame checks of scanning, masking and buffered loads
module tb_seven_segment_scanner;
  localparam int DC = 8;
  localparam int BC = 2;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] seg;
    logic [15:0] en;
  } vec_t;
  logic clock = 1'b0, resetN = 1'b1, loadValid = 1'b0;
  logic loadReady, frameStart;
  logic [31:0] digitData = '0;
  logic [3:0] digitMask = '0;
  logic [7:0] sevenSegmentData;
  logic [3:0] sevenSegmentEnable;
  int errors = 0, checks = 0;
  vec_t tbl[4];
  vec_t blank_v, l1, l2, l3, prev;

  seven_segment_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clock(clock), .resetN(resetN), .digitData(digitData), .digitMask(digitMask),
    .loadValid(loadValid), .loadReady(loadReady), .sevenSegmentData(sevenSegmentData),
    .sevenSegmentEnable(sevenSegmentEnable), .frameStart(frameStart)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // one clock of a frame: cycle i of 32, showing record v
  task automatic cyc(input vec_t v, input int i);
    int d;
    logic blank;
    step;
    d = i / DC;
    blank = (i % DC) < BC;
    chk("frameStart", i, 32'(frameStart), 32'(i == 0));
    chk("segData", i, 32'(sevenSegmentData), blank ? 32'hFF : 32'(v.seg[8*d +: 8]));
    chk("segEnable", i, 32'(sevenSegmentEnable), blank ? 32'hF : 32'(v.en[4*d +: 4]));
  endtask

  task automatic load(input vec_t v);
    digitData = v.data;
    digitMask = v.mask;
    loadValid = 1'b1;
  endtask

  task automatic frame(input vec_t shown, input int ld_at, input vec_t nv);
    for (int i = 0; i < 4 * DC; i++) begin
      cyc(shown, i);
      if (ld_at >= 0 && i == ld_at) begin
        chk("loadReady_before", i, 32'(loadReady), 32'd1);
        load(nv);
      end else if (ld_at >= 0 && i == ld_at + 1) begin
        chk("loadReady_after", i, 32'(loadReady), 32'd0);
        loadValid = 1'b0;
      end
    end
  endtask

  initial begin
    blank_v = {32'hFFFF_FFFF, 4'h0, 32'hFFFF_FFFF, 16'hFFFF};
    tbl[0] = {32'hB0A4_F9C0, 4'hF, 32'hB0A4_F9C0, 16'h7BDE};
    tbl[1] = {32'hB0A4_F9C0, 4'hB, 32'hB0FF_F9C0, 16'h7FDE};
    tbl[2] = {32'h1234_5678, 4'h1, 32'hFFFF_FF78, 16'hFFFE};
    tbl[3] = {32'h80FF_0011, 4'hC, 32'h80FF_FFFF, 16'h7BFF};
    l1 = {32'h92F8_A4C0, 4'hF, 32'h92F8_A4C0, 16'h7BDE};
    l2 = {32'h8883_8CC6, 4'h6, 32'hFF83_8CFF, 16'hFBDF};
    l3 = {32'h7F7F_7F7F, 4'h8, 32'h7FFF_FFFF, 16'h7FFF};
    #1 resetN = 1'b0;
    #1;
    chk("rst_async_en", 0, 32'(sevenSegmentEnable), 32'hF);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_en", 0, 32'(sevenSegmentEnable), 32'hF);
    chk("rst_seg", 0, 32'(sevenSegmentData), 32'hFF);
    chk("rst_fs", 0, 32'(frameStart), 32'd0);
    chk("rst_ready", 0, 32'(loadReady), 32'd1);
    resetN = 1'b1;
    frame(blank_v, -1, blank_v);
    prev = blank_v;
    for (int v = 0; v < 4; v++) begin
      frame(prev, 5, tbl[v]);
      prev = tbl[v];
    end
    // two loads in one frame: second held until after the boundary
    for (int i = 0; i < 4 * DC; i++) begin
      cyc(prev, i);
      if (i == 3) load(l1);
      if (i == 4) begin
        chk("two_ready_low", i, 32'(loadReady), 32'd0);
        load(l2);
      end
      if (i == 31) chk("two_ready_held", i, 32'(loadReady), 32'd0);
    end
    for (int i = 0; i < 4 * DC; i++) begin
      cyc(l1, i);
      if (i == 0) chk("two_ready_free", i, 32'(loadReady), 32'd1);
      if (i == 1) begin
        chk("two_second_taken", i, 32'(loadReady), 32'd0);
        loadValid = 1'b0;
      end
    end
    // load accepted exactly at the boundary edge waits one more frame
    for (int i = 0; i < 4 * DC; i++) begin
      cyc(l2, i);
      if (i == 31) begin
        chk("bnd_ready", i, 32'(loadReady), 32'd1);
        load(l3);
      end
    end
    for (int i = 0; i < 4 * DC; i++) begin
      cyc(l2, i);
      if (i == 0) begin
        chk("bnd_taken", i, 32'(loadReady), 32'd0);
        loadValid = 1'b0;
      end
    end
    // reset mid-SHOW with a load pending
    for (int i = 0; i <= 28; i++) begin
      cyc(l3, i);
      if (i == 20) load(tbl[0]);
      if (i == 21) begin
        chk("mid_pending", i, 32'(loadReady), 32'd0);
        loadValid = 1'b0;
      end
    end
    #2 resetN = 1'b0;
    #1;
    chk("mid_rst_en", 28, 32'(sevenSegmentEnable), 32'hF);
    chk("mid_rst_seg", 28, 32'(sevenSegmentData), 32'hFF);
    chk("mid_rst_fs", 28, 32'(frameStart), 32'd0);
    chk("mid_rst_ready", 28, 32'(loadReady), 32'd1);
    repeat (2) step;
    resetN = 1'b1;
    frame(blank_v, -1, blank_v);
    frame(blank_v, -1, blank_v);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
